// File: rtl/idli_cmp_m.sv
// Nibble-serial compare unit feeding the predicate register file Q write port.
// Optional TST/NTST support (nz accumulator) is enabled by defining IDLI_CMP_TST_EN.
module idli_cmp_m #(
    parameter int unsigned DATA_W = 16
) (
    input  logic       i_cmp_gck,
    input  logic       i_cmp_rst_n,
    input  logic       i_cmp_start,
    input  logic [2:0] i_cmp_op,
    input  logic [1:0] i_cmp_dst,
    input  logic       i_cmp_pred,
    input  logic [3:0] i_cmp_a,
    input  logic [3:0] i_cmp_b,
    output logic       o_cmp_busy,
    output logic       o_cmp_wr_en,
    output logic [1:0] o_cmp_wr_preg,
    output logic       o_cmp_wr_data
);

    localparam int unsigned NIB = DATA_W / 4;
    localparam int unsigned CW  = (NIB > 2) ? $clog2(NIB) : 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [1:0]    dst_q;
    logic          pred_q;
    logic          eq_q, brw_q;

    logic          accept, consume, last;
    logic          eq_in, brw_in;
    logic          eq_nx, brw_nx;
    logic [4:0]    nib_diff;
    logic          lt, result;

    assign accept  = (state == S_IDLE) && i_cmp_start;
    assign consume = accept || (state == S_RUN);
    assign last    = (state == S_RUN) && (cnt == CW'(NIB - 1));

    // Nibble 0 starts from fresh accumulator values instead of the stored ones.
    assign eq_in    = (state == S_IDLE) ? 1'b1 : eq_q;
    assign brw_in   = (state == S_IDLE) ? 1'b0 : brw_q;
    assign nib_diff = {1'b0, i_cmp_a} - {1'b0, i_cmp_b} - {4'b0000, brw_in};
    assign eq_nx    = eq_in && (i_cmp_a == i_cmp_b);
    assign brw_nx   = nib_diff[4];
    assign lt       = (i_cmp_a[3] ^ i_cmp_b[3]) ? i_cmp_a[3] : brw_nx;

`ifdef IDLI_CMP_TST_EN
    logic nz_q, nz_in, nz_nx;
    assign nz_in = (state == S_IDLE) ? 1'b0 : nz_q;
    assign nz_nx = nz_in || (|(i_cmp_a & i_cmp_b));

    always_ff @(posedge i_cmp_gck or negedge i_cmp_rst_n) begin
        if (!i_cmp_rst_n) begin
            nz_q <= 1'b0;
        end else if (consume) begin
            nz_q <= nz_nx;
        end
    end
`endif

    always_comb begin
        result = 1'b0;
        case (op_q)
            3'd0: result = eq_nx;
            3'd1: result = !eq_nx;
            3'd2: result = lt;
            3'd3: result = !lt;
            3'd4: result = brw_nx;
            3'd5: result = !brw_nx;
`ifdef IDLI_CMP_TST_EN
            3'd6: result = nz_nx;
            3'd7: result = !nz_nx;
`else
            3'd6: result = 1'b0;
            3'd7: result = 1'b0;
`endif
            default: result = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge i_cmp_gck or negedge i_cmp_rst_n) begin
        if (!i_cmp_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (i_cmp_start) state_nx = S_RUN;
            S_RUN:   if (last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_cmp_busy = (state == S_RUN);
    end

    always_ff @(posedge i_cmp_gck or negedge i_cmp_rst_n) begin
        if (!i_cmp_rst_n) begin
            cnt    <= '0;
            op_q   <= '0;
            dst_q  <= '0;
            pred_q <= 1'b0;
            eq_q   <= 1'b0;
            brw_q  <= 1'b0;
        end else begin
            if (accept) begin
                cnt    <= CW'(1);
                op_q   <= i_cmp_op;
                dst_q  <= i_cmp_dst;
                pred_q <= i_cmp_pred;
            end else if (state == S_RUN) begin
                cnt <= last ? '0 : cnt + CW'(1);
            end
            if (consume) begin
                eq_q  <= eq_nx;
                brw_q <= brw_nx;
            end
        end
    end

    // P3 is hardwired one, so writes to it are dropped along with predicated-off ones.
    always_ff @(posedge i_cmp_gck or negedge i_cmp_rst_n) begin
        if (!i_cmp_rst_n) begin
            o_cmp_wr_en   <= 1'b0;
            o_cmp_wr_preg <= '0;
            o_cmp_wr_data <= 1'b0;
        end else begin
            o_cmp_wr_en <= last && pred_q && (dst_q != 2'd3);
            if (last) begin
                o_cmp_wr_preg <= dst_q;
                o_cmp_wr_data <= result;
            end
        end
    end

endmodule
